board_render: RTL

BOARD_RENDER -- requirements
Module: board_render

---
 rtl/board_render.sv | 275 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/board_render.sv
// board_render: streams an ASCII picture of a tic-tac-toe board plus a
// status message to a UART transmitter, one byte per handshake.
// Optional feature macro: BOARD_RENDER_GRID_EN adds '|' between cells and
// "-+-+-" separator lines between rows; without it each row is 3 glyphs + CR LF.
//
// Handshake: o_valid/o_data describe the current byte and hold steady until
// a transfer (o_valid & i_ready on a rising edge); the next byte is presented
// in the following cycle.
module board_render (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [17:0] i_board,
  input  logic [1:0]  i_result,
  input  logic        i_isdraw,
  input  logic        i_ready,
  output logic [7:0]  o_data,
  output logic        o_valid,
  output logic        o_busy,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EMIT_ROW = 2'd1,
    EMIT_SEP = 2'd2,
    EMIT_MSG = 2'd3
  } state_t;

`ifdef BOARD_RENDER_GRID_EN
  localparam logic [2:0] ROW_LAST = 3'd6;
`else
  localparam logic [2:0] ROW_LAST = 3'd4;
`endif

  state_t      state_q, state_d;
  logic [1:0]  row_q, row_d;
  logic [2:0]  col_q, col_d;
  logic [2:0]  msg_q, msg_d;
  logic [17:0] board_q;
  logic [1:0]  result_q;
  logic        isdraw_q;
  logic        latch;
  logic        xfer;

  logic [1:0]  msg_kind;
  logic [2:0]  msg_last;
  logic [1:0]  cell_sel;
  logic [3:0]  cell_idx;
  logic [1:0]  cell_code;
  logic [7:0]  glyph;
  logic [7:0]  row_byte;
  logic [7:0]  sep_byte;
  logic [7:0]  msg_byte;

  assign xfer        = o_valid & i_ready;
  assign o_valid     = (state_q != IDLE);
  assign o_busy      = (state_q != IDLE);
  assign o_dbg_state = state_q;

  // Pick the message: X win, then O win, then draw, otherwise the move prompt.
  always_comb begin
    msg_kind = 2'd0;
    msg_last = 3'd5;
    if (result_q == 2'd1) begin
      msg_kind = 2'd1;
      msg_last = 3'd7;
    end else if (result_q == 2'd2) begin
      msg_kind = 2'd2;
      msg_last = 3'd7;
    end else if (isdraw_q) begin
      msg_kind = 2'd3;
      msg_last = 3'd5;
    end
  end

  // Map the column position onto a cell and build its glyph.
  always_comb begin
    cell_sel = 2'd0;
`ifdef BOARD_RENDER_GRID_EN
    case (col_q)
      3'd2:    cell_sel = 2'd1;
      3'd4:    cell_sel = 2'd2;
      default: cell_sel = 2'd0;
    endcase
`else
    cell_sel = (col_q <= 3'd2) ? col_q[1:0] : 2'd0;
`endif
    cell_idx  = ({2'b00, row_q} * 4'd3) + {2'b00, cell_sel};
    cell_code = board_q[{cell_idx, 1'b0} +: 2];
    case (cell_code)
      2'b00:   glyph = 8'h31 + {4'b0000, cell_idx};
      2'b01:   glyph = 8'h4F;
      2'b11:   glyph = 8'h58;
      default: glyph = 8'h3F;
    endcase
  end

  // Byte of the current row line.
  always_comb begin
    row_byte = 8'h00;
`ifdef BOARD_RENDER_GRID_EN
    case (col_q)
      3'd0, 3'd2, 3'd4: row_byte = glyph;
      3'd1, 3'd3:       row_byte = 8'h7C;
      3'd5:             row_byte = 8'h0D;
      3'd6:             row_byte = 8'h0A;
      default:          row_byte = 8'h00;
    endcase
`else
    case (col_q)
      3'd0, 3'd1, 3'd2: row_byte = glyph;
      3'd3:             row_byte = 8'h0D;
      3'd4:             row_byte = 8'h0A;
      default:          row_byte = 8'h00;
    endcase
`endif
  end

  // Byte of the separator line "-+-+-" CR LF.
  always_comb begin
    case (col_q)
      3'd0, 3'd2, 3'd4: sep_byte = 8'h2D;
      3'd1, 3'd3:       sep_byte = 8'h2B;
      3'd5:             sep_byte = 8'h0D;
      3'd6:             sep_byte = 8'h0A;
      default:          sep_byte = 8'h00;
    endcase
  end

  // Message text lookup; idx 0..7 covers the longest message.
  always_comb begin
    msg_byte = 8'h00;
    case (msg_kind)
      2'd1, 2'd2: begin
        case (msg_q)
          3'd0:    msg_byte = (msg_kind == 2'd1) ? 8'h58 : 8'h4F;
          3'd1:    msg_byte = 8'h20;
          3'd2:    msg_byte = 8'h77;
          3'd3:    msg_byte = 8'h69;
          3'd4:    msg_byte = 8'h6E;
          3'd5:    msg_byte = 8'h73;
          3'd6:    msg_byte = 8'h0D;
          default: msg_byte = 8'h0A;
        endcase
      end
      2'd3: begin
        case (msg_q)
          3'd0:    msg_byte = 8'h44;
          3'd1:    msg_byte = 8'h72;
          3'd2:    msg_byte = 8'h61;
          3'd3:    msg_byte = 8'h77;
          3'd4:    msg_byte = 8'h0D;
          default: msg_byte = 8'h0A;
        endcase
      end
      default: begin
        case (msg_q)
          3'd0:    msg_byte = 8'h4D;
          3'd1:    msg_byte = 8'h6F;
          3'd2:    msg_byte = 8'h76;
          3'd3:    msg_byte = 8'h65;
          3'd4:    msg_byte = 8'h3F;
          default: msg_byte = 8'h20;
        endcase
      end
    endcase
  end

  // Output byte multiplexer; idle drives zero.
  always_comb begin
    case (state_q)
      EMIT_ROW: o_data = row_byte;
      EMIT_SEP: o_data = sep_byte;
      EMIT_MSG: o_data = msg_byte;
      default:  o_data = 8'h00;
    endcase
  end

  // Next-state and position counters; positions only move on a transfer.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    msg_d   = msg_q;
    latch   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          latch   = 1'b1;
          state_d = EMIT_ROW;
          row_d   = 2'd0;
          col_d   = 3'd0;
          msg_d   = 3'd0;
        end
      end
      EMIT_ROW: begin
        if (xfer) begin
          if (col_q == ROW_LAST) begin
            col_d = 3'd0;
            if (row_q == 2'd2) begin
              state_d = EMIT_MSG;
              msg_d   = 3'd0;
            end else begin
`ifdef BOARD_RENDER_GRID_EN
              state_d = EMIT_SEP;
`else
              row_d   = row_q + 2'd1;
`endif
            end
          end else begin
            col_d = col_q + 3'd1;
          end
        end
      end
      EMIT_SEP: begin
        if (xfer) begin
          if (col_q == 3'd6) begin
            col_d   = 3'd0;
            row_d   = row_q + 2'd1;
            state_d = EMIT_ROW;
          end else begin
            col_d = col_q + 3'd1;
          end
        end
      end
      EMIT_MSG: begin
        if (xfer) begin
          if (msg_q == msg_last) begin
            state_d = IDLE;
            msg_d   = 3'd0;
            row_d   = 2'd0;
          end else begin
            msg_d = msg_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        row_d   = 2'd0;
        col_d   = 3'd0;
        msg_d   = 3'd0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      row_q   <= 2'd0;
      col_q   <= 3'd0;
      msg_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      msg_q   <= msg_d;
    end
  end

  // Snapshot of the game inputs, taken only when a render is accepted.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      board_q  <= 18'd0;
      result_q <= 2'd0;
      isdraw_q <= 1'b0;
    end else if (latch) begin
      board_q  <= i_board;
      result_q <= i_result;
      isdraw_q <= i_isdraw;
    end
  end

endmodule
